rv32_writeback_unit: RTL and testbench

Single-port register-file writeback unit for the RV32 core. It owns the register file's write port (`write_reg`, `sel_d1`, `reg_d1`) and arbitrates between ALU results and load data returning from data memory. It tracks outstanding loads in an in-order queue, formats returned load data (byte/halfword extraction, sign/zero extension), and exports a per-register busy mask that decode uses for load-use stalls.

---
 rtl/rv32_writeback_unit.sv | 168 ++++++++++++++++
 tb/tb_rv32_writeback_unit.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_writeback_unit.sv
// RV32 register-file writeback unit: in-order load queue, load formatting and
// ALU/load write-port arbitration. Define RV32_WB_ALIGN_CHECK_EN to flag and suppress misaligned loads.
module rv32_writeback_unit #(
    parameter int LQ_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [4:0]                 alu_rd,
    input  logic [31:0]                alu_data,
    input  logic                       ld_issue_valid,
    output logic                       ld_issue_ready,
    input  logic [4:0]                 ld_issue_rd,
    input  logic [2:0]                 ld_issue_funct3,
    input  logic [1:0]                 ld_issue_addr_lo,
    input  logic                       mem_rsp_valid,
    output logic                       mem_rsp_ready,
    input  logic [31:0]                mem_rsp_data,
    output logic                       write_reg,
    output logic [4:0]                 sel_d1,
    output logic [31:0]                reg_d1,
    output logic [31:0]                busy_mask,
    output logic [$clog2(LQ_DEPTH):0]  lq_count,
    output logic                       misalign_err
);

    localparam int PTR_W = $clog2(LQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LQ_DEPTH);

    // Shift the word down by the byte offset (zero-filling from above), then extract/extend.
    function automatic logic [31:0] format_load(input logic [31:0] raw,
                                                input logic [2:0]  funct3,
                                                input logic [1:0]  addr_lo);
        logic [31:0] sh;
        sh = raw >> {addr_lo, 3'b000};
        case (funct3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'h000000, sh[7:0]};
            3'b101:  return {16'h0000, sh[15:0]};
            default: return sh;
        endcase
    endfunction

`ifdef RV32_WB_ALIGN_CHECK_EN
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        case (funct3)
            3'b001, 3'b101:                 return addr_lo[0];
            3'b010, 3'b011, 3'b110, 3'b111: return (addr_lo != 2'b00);
            default:                        return 1'b0;
        endcase
    endfunction
`endif

    logic [4:0]          lq_rd_r     [LQ_DEPTH];
    logic [2:0]          lq_funct3_r [LQ_DEPTH];
    logic [1:0]          lq_addr_r   [LQ_DEPTH];
    logic                lq_mis_r    [LQ_DEPTH];
    logic [LQ_DEPTH-1:0] lq_valid_r;
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;

    logic        push_s;
    logic        pop_s;
    logic        issue_mis_s;
    logic [4:0]  head_rd_s;
    logic        head_mis_s;
    logic [31:0] load_data_s;
    logic [31:0] busy_s;

    assign ld_issue_ready = (lq_count != CNT_FULL);
    assign mem_rsp_ready  = (lq_count != {CNT_W{1'b0}});
    assign push_s         = ld_issue_valid && ld_issue_ready;
    assign pop_s          = mem_rsp_valid && mem_rsp_ready;
    assign alu_ready      = !pop_s;

    assign head_rd_s   = lq_rd_r[rd_ptr_r];
    assign head_mis_s  = lq_mis_r[rd_ptr_r];
    assign load_data_s = format_load(mem_rsp_data, lq_funct3_r[rd_ptr_r], lq_addr_r[rd_ptr_r]);

`ifdef RV32_WB_ALIGN_CHECK_EN
    logic misalign_r;
    assign issue_mis_s  = is_misaligned(ld_issue_funct3, ld_issue_addr_lo);
    assign misalign_err = misalign_r;

    // Registered one-cycle misalignment pulse following the issue handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_r <= 1'b0;
        end else begin
            misalign_r <= push_s && issue_mis_s;
        end
    end
`else
    assign issue_mis_s  = 1'b0;
    assign misalign_err = 1'b0;
`endif

    // Load queue storage, pointers, per-entry valid bits and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            lq_valid_r <= '0;
            lq_count   <= '0;
            for (int i = 0; i < LQ_DEPTH; i++) begin
                lq_rd_r[i]     <= 5'd0;
                lq_funct3_r[i] <= 3'd0;
                lq_addr_r[i]   <= 2'd0;
                lq_mis_r[i]    <= 1'b0;
            end
        end else begin
            if (push_s) begin
                lq_rd_r[wr_ptr_r]     <= ld_issue_rd;
                lq_funct3_r[wr_ptr_r] <= ld_issue_funct3;
                lq_addr_r[wr_ptr_r]   <= ld_issue_addr_lo;
                lq_mis_r[wr_ptr_r]    <= issue_mis_s;
                lq_valid_r[wr_ptr_r]  <= 1'b1;
                wr_ptr_r              <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                lq_valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r             <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   lq_count <= lq_count + CNT_ONE;
                2'b01:   lq_count <= lq_count - CNT_ONE;
                default: lq_count <= lq_count;
            endcase
        end
    end

    // Busy mask: one-hot rd of every queued load, register 0 never busy.
    always_comb begin
        busy_s = 32'h0000_0000;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            busy_s = busy_s | (lq_valid_r[i] ? (32'h0000_0001 << lq_rd_r[i]) : 32'h0000_0000);
        end
        busy_s[0] = 1'b0;
    end

    assign busy_mask = busy_s;

    // Write port: load response has priority; the ALU result is taken only when no response pops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_reg <= 1'b0;
            sel_d1    <= 5'd0;
            reg_d1    <= 32'h0000_0000;
        end else if (pop_s) begin
            write_reg <= (head_rd_s != 5'd0) && !head_mis_s;
            sel_d1    <= head_rd_s;
            reg_d1    <= load_data_s;
        end else if (alu_valid) begin
            write_reg <= (alu_rd != 5'd0);
            sel_d1    <= alu_rd;
            reg_d1    <= alu_data;
        end else begin
            write_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rv32_writeback_unit.sv
// Self-checking bench for rv32_writeback_unit: directed feature tests plus a
// randomized run against a queue-based reference model.
module tb_rv32_writeback_unit;

    localparam int DEPTH = 4;

    logic        clk, rst_n;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_issue_valid, ld_issue_ready;
    logic [4:0]  ld_issue_rd;
    logic [2:0]  ld_issue_funct3;
    logic [1:0]  ld_issue_addr_lo;
    logic        mem_rsp_valid, mem_rsp_ready;
    logic [31:0] mem_rsp_data;
    logic        write_reg;
    logic [4:0]  sel_d1;
    logic [31:0] reg_d1;
    logic [31:0] busy_mask;
    logic [2:0]  lq_count;
    logic        misalign_err;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [4:0] rd;
        logic [2:0] f3;
        logic [1:0] a;
        logic       mis;
    } ent_t;
    ent_t q[$];

    rv32_writeback_unit #(.LQ_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_issue_valid(ld_issue_valid), .ld_issue_ready(ld_issue_ready),
        .ld_issue_rd(ld_issue_rd), .ld_issue_funct3(ld_issue_funct3),
        .ld_issue_addr_lo(ld_issue_addr_lo),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data),
        .write_reg(write_reg), .sel_d1(sel_d1), .reg_d1(reg_d1),
        .busy_mask(busy_mask), .lq_count(lq_count), .misalign_err(misalign_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference load formatting: pick bytes out of a little-endian byte list.
    function automatic logic [31:0] ref_format(logic [31:0] w, logic [2:0] f3, logic [1:0] a);
        logic [7:0] b [0:7];
        int o;
        for (int k = 0; k < 8; k++) b[k] = (k < 4) ? w[8*k +: 8] : 8'h00;
        o = int'(a);
        case (f3)
            3'b000:  return {{24{b[o][7]}}, b[o]};
            3'b001:  return {{16{b[o+1][7]}}, b[o+1], b[o]};
            3'b100:  return {24'h0, b[o]};
            3'b101:  return {16'h0, b[o+1], b[o]};
            default: return {b[o+3], b[o+2], b[o+1], b[o]};
        endcase
    endfunction

    function automatic logic ref_mis(logic [2:0] f3, logic [1:0] a);
`ifdef RV32_WB_ALIGN_CHECK_EN
        if (f3 == 3'b001 || f3 == 3'b101) return a[0];
        if (f3[1]) return (a != 2'b00);
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'h0;
        ld_issue_valid = 1'b0; ld_issue_rd = 5'd0; ld_issue_funct3 = 3'b000; ld_issue_addr_lo = 2'b00;
        mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
    endtask

    task automatic issue_load(logic [4:0] rd, logic [2:0] f3, logic [1:0] a);
        ld_issue_valid = 1'b1; ld_issue_rd = rd; ld_issue_funct3 = f3; ld_issue_addr_lo = a;
        tick();
        ld_issue_valid = 1'b0;
    endtask

    task automatic respond(logic [31:0] d);
        mem_rsp_valid = 1'b1; mem_rsp_data = d;
        tick();
        mem_rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (write_reg !== 1'b0) begin miscompares++; $display("FAIL rst_we got %0b exp 0", write_reg); end
        vectors++; if (sel_d1 !== 5'd0) begin miscompares++; $display("FAIL rst_sel got %0d exp 0", sel_d1); end
        vectors++; if (reg_d1 !== 32'h0) begin miscompares++; $display("FAIL rst_data got %h exp 0", reg_d1); end
        vectors++; if (lq_count !== 3'd0) begin miscompares++; $display("FAIL rst_count got %0d exp 0", lq_count); end
        vectors++; if (busy_mask !== 32'h0) begin miscompares++; $display("FAIL rst_busy got %h exp 0", busy_mask); end
        vectors++; if (ld_issue_ready !== 1'b1) begin miscompares++; $display("FAIL rst_issue_rdy got %0b exp 1", ld_issue_ready); end
        vectors++; if (mem_rsp_ready !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_rdy got %0b exp 0", mem_rsp_ready); end
        vectors++; if (misalign_err !== 1'b0) begin miscompares++; $display("FAIL rst_mis got %0b exp 0", misalign_err); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu_write();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        tick();
        alu_valid = 1'b0;
        vectors++; if (write_reg !== 1'b1) begin miscompares++; $display("FAIL alu_we got %0b exp 1", write_reg); end
        vectors++; if (sel_d1 !== 5'd5) begin miscompares++; $display("FAIL alu_sel got %0d exp 5", sel_d1); end
        vectors++; if (reg_d1 !== 32'hDEADBEEF) begin miscompares++; $display("FAIL alu_data got %h exp deadbeef", reg_d1); end
        tick();
        vectors++; if (write_reg !== 1'b0) begin miscompares++; $display("FAIL idle_we got %0b exp 0", write_reg); end
        vectors++; if (sel_d1 !== 5'd5 || reg_d1 !== 32'hDEADBEEF) begin
            miscompares++; $display("FAIL idle_hold got %0d/%h exp 5/deadbeef", sel_d1, reg_d1); end
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h12345678;
        tick();
        alu_valid = 1'b0;
        vectors++; if (write_reg !== 1'b0) begin miscompares++; $display("FAIL alu_x0_we got %0b exp 0", write_reg); end
    endtask

    task automatic test_byte_load();
        issue_load(5'd7, 3'b000, 2'd3);
        vectors++; if (lq_count !== 3'd1) begin miscompares++; $display("FAIL lb_count got %0d exp 1", lq_count); end
        vectors++; if (busy_mask !== 32'h80) begin miscompares++; $display("FAIL lb_busy got %h exp 80", busy_mask); end
        vectors++; if (mem_rsp_ready !== 1'b1) begin miscompares++; $display("FAIL lb_rsp_rdy got %0b exp 1", mem_rsp_ready); end
        respond(32'h80123456);
        vectors++; if (write_reg !== 1'b1 || sel_d1 !== 5'd7) begin
            miscompares++; $display("FAIL lb_we got %0b/%0d exp 1/7", write_reg, sel_d1); end
        vectors++; if (reg_d1 !== 32'hFFFFFF80) begin miscompares++; $display("FAIL lb_data got %h exp ffffff80", reg_d1); end
        vectors++; if (busy_mask !== 32'h0) begin miscompares++; $display("FAIL lb_busy_clr got %h exp 0", busy_mask); end
        issue_load(5'd7, 3'b100, 2'd3);
        respond(32'h80123456);
        vectors++; if (reg_d1 !== 32'h00000080) begin miscompares++; $display("FAIL lbu_data got %h exp 00000080", reg_d1); end
    endtask

    task automatic test_half_load();
        issue_load(5'd12, 3'b001, 2'd2);
        respond(32'h80011234);
        vectors++; if (reg_d1 !== 32'hFFFF8001) begin miscompares++; $display("FAIL lh_data got %h exp ffff8001", reg_d1); end
        issue_load(5'd12, 3'b101, 2'd0);
        respond(32'h80011234);
        vectors++; if (reg_d1 !== 32'h00001234) begin miscompares++; $display("FAIL lhu_data got %h exp 00001234", reg_d1); end
    endtask

    task automatic test_conflict();
        issue_load(5'd9, 3'b010, 2'd0);
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA5A5A5A5;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h12345678;
        #1;
        vectors++; if (alu_ready !== 1'b0) begin miscompares++; $display("FAIL cf_alu_rdy got %0b exp 0", alu_ready); end
        tick();
        mem_rsp_valid = 1'b0;
        vectors++; if (write_reg !== 1'b1 || sel_d1 !== 5'd9 || reg_d1 !== 32'h12345678) begin
            miscompares++; $display("FAIL cf_load got %0b/%0d/%h exp 1/9/12345678", write_reg, sel_d1, reg_d1); end
        #1;
        vectors++; if (alu_ready !== 1'b1) begin miscompares++; $display("FAIL cf_alu_rdy2 got %0b exp 1", alu_ready); end
        tick();
        alu_valid = 1'b0;
        vectors++; if (write_reg !== 1'b1 || sel_d1 !== 5'd10 || reg_d1 !== 32'hA5A5A5A5) begin
            miscompares++; $display("FAIL cf_alu got %0b/%0d/%h exp 1/10/a5a5a5a5", write_reg, sel_d1, reg_d1); end
        tick();
    endtask

    task automatic test_full_queue();
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd3; ld_issue_funct3 = 3'b010; ld_issue_addr_lo = 2'd0;
        repeat (4) tick();
        vectors++; if (lq_count !== 3'd4) begin miscompares++; $display("FAIL fq_count got %0d exp 4", lq_count); end
        vectors++; if (ld_issue_ready !== 1'b0) begin miscompares++; $display("FAIL fq_rdy got %0b exp 0", ld_issue_ready); end
        vectors++; if (busy_mask !== 32'h8) begin miscompares++; $display("FAIL fq_busy got %h exp 8", busy_mask); end
        tick();
        vectors++; if (lq_count !== 3'd4) begin miscompares++; $display("FAIL fq_over got %0d exp 4", lq_count); end
        mem_rsp_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_rsp_data = 32'h100 + i;
            tick();
            ld_issue_valid = 1'b0;
            vectors++; if (write_reg !== 1'b1 || reg_d1 !== 32'h100 + i) begin
                miscompares++; $display("FAIL fq_wr%0d got %0b/%h exp 1/%h", i, write_reg, reg_d1, 32'h100 + i); end
            vectors++; if (busy_mask !== ((i < 3) ? 32'h8 : 32'h0)) begin
                miscompares++; $display("FAIL fq_busy%0d got %h exp %h", i, busy_mask, (i < 3) ? 32'h8 : 32'h0); end
            vectors++; if (lq_count !== 3'(3 - i)) begin
                miscompares++; $display("FAIL fq_cnt%0d got %0d exp %0d", i, lq_count, 3 - i); end
        end
        mem_rsp_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        issue_load(5'd4, 3'b010, 2'd0);
        issue_load(5'd6, 3'b010, 2'd0);
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h55;
        rst_n = 1'b0;
        #1;
        vectors++; if (lq_count !== 3'd0 || busy_mask !== 32'h0) begin
            miscompares++; $display("FAIL rm_state got %0d/%h exp 0/0", lq_count, busy_mask); end
        vectors++; if (write_reg !== 1'b0 || mem_rsp_ready !== 1'b0 || ld_issue_ready !== 1'b1) begin
            miscompares++; $display("FAIL rm_ctl got we%0b rr%0b ir%0b exp 0/0/1", write_reg, mem_rsp_ready, ld_issue_ready); end
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        vectors++; if (write_reg !== 1'b0 || lq_count !== 3'd0) begin
            miscompares++; $display("FAIL rm_after got %0b/%0d exp 0/0", write_reg, lq_count); end
    endtask

    task automatic test_misalign();
        issue_load(5'd11, 3'b010, 2'd1);
`ifdef RV32_WB_ALIGN_CHECK_EN
        vectors++; if (misalign_err !== 1'b1) begin miscompares++; $display("FAIL ma_pulse got %0b exp 1", misalign_err); end
`else
        vectors++; if (misalign_err !== 1'b0) begin miscompares++; $display("FAIL ma_tied got %0b exp 0", misalign_err); end
`endif
        vectors++; if (lq_count !== 3'd1) begin miscompares++; $display("FAIL ma_count got %0d exp 1", lq_count); end
        tick();
        vectors++; if (misalign_err !== 1'b0) begin miscompares++; $display("FAIL ma_end got %0b exp 0", misalign_err); end
        respond(32'hCAFEF00D);
`ifdef RV32_WB_ALIGN_CHECK_EN
        vectors++; if (write_reg !== 1'b0) begin miscompares++; $display("FAIL ma_nowr got %0b exp 0", write_reg); end
`else
        vectors++; if (write_reg !== 1'b1) begin miscompares++; $display("FAIL ma_wr got %0b exp 1", write_reg); end
`endif
        vectors++; if (lq_count !== 3'd0) begin miscompares++; $display("FAIL ma_drain got %0d exp 0", lq_count); end
    endtask

    task automatic test_random();
        logic        pop, push, exp_we, exp_mis;
        logic [4:0]  exp_sel;
        logic [31:0] exp_data, exp_busy;
        ent_t        e, h;
        q.delete();
        for (int n = 0; n < 600; n++) begin
            alu_valid = ($urandom_range(0, 1) == 1);
            alu_rd = 5'($urandom_range(0, 7));
            alu_data = $urandom();
            ld_issue_valid = ($urandom_range(0, 2) != 0);
            ld_issue_rd = 5'($urandom_range(0, 7));
            ld_issue_funct3 = 3'($urandom_range(0, 7));
            case (ld_issue_funct3)
                3'b000, 3'b100: ld_issue_addr_lo = 2'($urandom_range(0, 3));
                3'b001, 3'b101: ld_issue_addr_lo = {1'($urandom_range(0, 1)), 1'b0};
                default:        ld_issue_addr_lo = 2'b00;
            endcase
            mem_rsp_valid = ($urandom_range(0, 2) != 0);
            mem_rsp_data = $urandom();

            pop  = mem_rsp_valid && (q.size() > 0);
            push = ld_issue_valid && (q.size() < DEPTH);
            #1;
            vectors++; if (alu_ready !== !pop) begin
                miscompares++; $display("FAIL rnd_alu_rdy n%0d got %0b exp %0b", n, alu_ready, !pop); end
            vectors++; if (ld_issue_ready !== (q.size() < DEPTH) || mem_rsp_ready !== (q.size() > 0)) begin
                miscompares++; $display("FAIL rnd_rdy n%0d got %0b/%0b exp %0b/%0b", n, ld_issue_ready,
                                        mem_rsp_ready, q.size() < DEPTH, q.size() > 0); end

            exp_we = 1'b0; exp_sel = 5'd0; exp_data = 32'h0;
            exp_mis = push && ref_mis(ld_issue_funct3, ld_issue_addr_lo);
            if (pop) begin
                h = q.pop_front();
                exp_we = (h.rd != 5'd0) && !h.mis;
                exp_sel = h.rd;
                exp_data = ref_format(mem_rsp_data, h.f3, h.a);
            end else if (alu_valid) begin
                exp_we = (alu_rd != 5'd0);
                exp_sel = alu_rd;
                exp_data = alu_data;
            end
            if (push) begin
                e.rd = ld_issue_rd; e.f3 = ld_issue_funct3; e.a = ld_issue_addr_lo;
                e.mis = ref_mis(ld_issue_funct3, ld_issue_addr_lo);
                q.push_back(e);
            end
            exp_busy = 32'h0;
            foreach (q[k]) if (q[k].rd != 5'd0) exp_busy[q[k].rd] = 1'b1;

            @(posedge clk);
            #1;
            vectors++; if (write_reg !== exp_we) begin
                miscompares++; $display("FAIL rnd_we n%0d got %0b exp %0b", n, write_reg, exp_we); end
            if (exp_we) begin
                vectors++; if (sel_d1 !== exp_sel || reg_d1 !== exp_data) begin
                    miscompares++; $display("FAIL rnd_wr n%0d got %0d/%h exp %0d/%h", n, sel_d1, reg_d1, exp_sel, exp_data); end
            end
            vectors++; if (lq_count !== 3'(q.size()) || busy_mask !== exp_busy) begin
                miscompares++; $display("FAIL rnd_q n%0d got %0d/%h exp %0d/%h", n, lq_count, busy_mask, q.size(), exp_busy); end
            vectors++; if (misalign_err !== exp_mis) begin
                miscompares++; $display("FAIL rnd_mis n%0d got %0b exp %0b", n, misalign_err, exp_mis); end
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_byte_load();
        test_half_load();
        test_conflict();
        test_full_queue();
        test_reset_mid();
        test_misalign();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
